// File: rtl/priority_encoder_8to3_pkg.sv
// Shared widths, state encoding and helpers for the 8-to-3 priority encoder.
package priority_encoder_8to3_pkg;

  localparam int unsigned REQ_W  = 8;
  localparam int unsigned CODE_W = 3;

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_PRESENT = 1'b1;

  typedef enum logic {
    StIdle    = ST_IDLE,
    StPresent = ST_PRESENT
  } state_e;

  function automatic logic [REQ_W-1:0] onehot(input logic [CODE_W-1:0] idx);
    return REQ_W'(1) << idx;
  endfunction

endpackage

// File: rtl/priority_encoder_8to3_prio_enc8.sv
// Combinational 8->3 encoder: index of the highest set bit, plus an any flag.
module prio_enc8
  import priority_encoder_8to3_pkg::*;
(
  input  logic [REQ_W-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Ascending scan so the highest set bit is the last to assign.
  always_comb begin
    code = '0;
    for (int i = 0; i < REQ_W; i++) begin
      if (vec[i]) code = CODE_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder with sticky request capture and valid/ack handshake.
module priority_encoder_8to3
  import priority_encoder_8to3_pkg::*;
#(
  parameter int unsigned SERVICED_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [REQ_W-1:0]      req,
  input  logic                  ack,
  output logic [CODE_W-1:0]     out,
  output logic                  valid,
  output logic [REQ_W-1:0]      pending,
  output logic [SERVICED_W-1:0] serviced_cnt
);

  state_e                state_q;
  logic [REQ_W-1:0]      pending_q, pending_d, clr_mask;
  logic [CODE_W-1:0]     out_q, next_code;
  logic [SERVICED_W-1:0] cnt_q;
  logic                  handshake, next_any, load;

  assign handshake = (state_q == StPresent) & ack;
  assign clr_mask  = handshake ? onehot(out_q) : '0;
  // New requests are ORed in after the clear, so a re-request survives its own ack.
  assign pending_d = (pending_q & ~clr_mask) | req;

  prio_enc8 u_enc (
    .vec  (pending_d),
    .code (next_code),
    .any  (next_any)
  );

  assign load = enable & next_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      if (handshake && (cnt_q != '1)) cnt_q <= cnt_q + SERVICED_W'(1);
      case (state_q)
        StIdle: begin
          if (load) begin
            out_q   <= next_code;
            state_q <= StPresent;
          end
        end
        StPresent: begin
          // Without ack the presented code is frozen regardless of enable.
          if (ack) begin
            if (load) out_q <= next_code;
            else      state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out          = out_q;
  assign valid        = (state_q == StPresent);
  assign pending      = pending_q;
  assign serviced_cnt = cnt_q;

endmodule
